// File: rtl/cpu_mu0_core.sv
// MU0 accumulator CPU architectural datapath.
// Holds pc, acc and the run flag and executes the instruction presented on
// instr in every cycle where validRead is high. Fetch sequencing, memory
// strobes and the instruction register live in the wrapper above this block.
module cpu_mu0_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic [15:0] readdata,
  input  logic        validRead,
  output logic [11:0] pc,
  output logic [15:0] writedata,
  output logic        running
);

  typedef enum logic [3:0] {
    OP_LDA = 4'd0,
    OP_STO = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_JMP = 4'd4,
    OP_JGE = 4'd5,
    OP_JNE = 4'd6,
    OP_STP = 4'd7,
    OP_OUT = 4'd8
  } opcode_e;

  logic [3:0]  opcode;
  logic [11:0] operand;
  logic [15:0] acc;
  logic [15:0] acc_next;
  logic [11:0] pc_next;
  logic [11:0] pc_inc;
  logic        running_next;

  assign opcode    = instr[15:12];
  assign operand   = instr[11:0];
  assign pc_inc    = pc + 12'd1;
  assign writedata = acc;

  // Decode the current instruction into the next architectural state; jump
  // conditions look at acc as it stands before this instruction retires.
  always_comb begin
    acc_next     = acc;
    pc_next      = pc_inc;
    running_next = running;
    case (opcode)
      OP_LDA: acc_next = readdata;
      OP_STO: acc_next = acc;
      OP_ADD: acc_next = acc + readdata;
      OP_SUB: acc_next = acc - readdata;
      OP_JMP: pc_next  = operand;
      OP_JGE: pc_next  = acc[15] ? pc_inc : operand;
      OP_JNE: pc_next  = (acc != 16'h0000) ? operand : pc_inc;
      OP_STP: begin
        pc_next      = pc;
        running_next = 1'b0;
      end
      OP_OUT: acc_next = acc;
      default: acc_next = acc;
    endcase
  end

  // Commit state only on execute cycles while running; once halted,
  // everything freezes until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= 12'h000;
      acc     <= 16'h0000;
      running <= 1'b1;
    end else if (running && validRead) begin
      pc      <= pc_next;
      acc     <= acc_next;
      running <= running_next;
    end
  end

endmodule

// File: tb/tb_cpu_mu0_core.sv
// Self-checking bench for cpu_mu0_core: directed test-plan sequence with
// literal expectations, then randomized instructions against a reference model.
`timescale 1ns/1ps
module tb_cpu_mu0_core;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [15:0] readdata;
  logic        validRead;
  logic [11:0] pc;
  logic [15:0] writedata;
  logic        running;

  int checks = 0;
  int passes = 0;
  bit cmpEn  = 0;

  // Reference architectural state
  int unsigned mPc;
  int unsigned mAcc;
  bit          mRun;

  cpu_mu0_core dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .readdata  (readdata),
    .validRead (validRead),
    .pc        (pc),
    .writedata (writedata),
    .running   (running)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    mPc  = 0;
    mAcc = 0;
    mRun = 1;
  endtask

  // Architectural effect of one executed instruction
  task automatic modelStep(input int op, input int s, input int rd);
    int unsigned nextPc;
    if (!mRun) return;
    nextPc = (mPc + 1) % 4096;
    case (op)
      0: mAcc = rd;
      2: mAcc = (mAcc + rd) % 65536;
      3: mAcc = (mAcc + 65536 - rd) % 65536;
      4: nextPc = s;
      5: if (mAcc < 32768) nextPc = s;
      6: if (mAcc != 0) nextPc = s;
      7: begin
        nextPc = mPc;
        mRun   = 0;
      end
      default: ;
    endcase
    mPc = nextPc;
  endtask

  task automatic checkLiteral(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput();
    checks++;
    if (pc == mPc[11:0] && writedata == mAcc[15:0] && running == mRun) passes++;
    else $display("[TB] FAIL model t=%0t: pc/acc/run got %03h/%04h/%0b, want %03h/%04h/%0b",
                  $time, pc, writedata, running, mPc[11:0], mAcc[15:0], mRun);
  endtask

  // One input cycle; inputs change 1 ns after the rising edge
  task automatic applyStimulus(input int op, input int s, input int rd, input bit vr);
    instr     = {op[3:0], s[11:0]};
    readdata  = rd[15:0];
    validRead = vr;
    @(posedge clk);
    if (vr) modelStep(op, s, rd);
    #1;
  endtask

  // Mid-cycle asynchronous reset, with a competing execute during the reset edge
  task automatic doReset();
    #2;
    rst = 0;
    modelReset();
    #1;
    checkLiteral("async_rst_pc", pc, 0);
    checkLiteral("async_rst_acc", writedata, 0);
    checkLiteral("async_rst_run", running, 1);
    instr     = 16'h0123;
    readdata  = 16'hFFFF;
    validRead = 1;
    @(posedge clk);
    #1;
    rst       = 1;
    validRead = 0;
  endtask

  // Compare DUT against the model at every falling edge
  always @(negedge clk) if (cmpEn) checkOutput();

  initial begin
    int op;
    rst = 0; instr = 0; readdata = 0; validRead = 0;
    modelReset();
    @(posedge clk);
    #1;
    rst   = 1;
    cmpEn = 1;

    doReset();
    for (int i = 0; i < 5; i++) applyStimulus($urandom_range(0, 15), $urandom_range(0, 4095), $urandom_range(0, 65535), 0);
    checkLiteral("idle_pc", pc, 0);
    checkLiteral("idle_acc", writedata, 0);
    checkLiteral("idle_run", running, 1);

    applyStimulus(0, 12'h020, 16'h0005, 1);
    checkLiteral("lda_acc", writedata, 16'h0005);
    checkLiteral("lda_pc", pc, 1);
    applyStimulus(2, 12'h021, 16'h0003, 1);
    checkLiteral("add_acc", writedata, 16'h0008);
    applyStimulus(3, 12'h022, 16'h0009, 1);
    checkLiteral("sub_acc", writedata, 16'hFFFF);
    checkLiteral("sub_pc", pc, 3);
    applyStimulus(2, 12'h023, 16'h0001, 1);
    checkLiteral("add_wrap", writedata, 16'h0000);

    applyStimulus(4, 12'h123, 16'hBEEF, 1);
    checkLiteral("jmp_pc", pc, 12'h123);
    applyStimulus(0, 12'h000, 16'h8000, 1);
    applyStimulus(5, 12'h050, 16'h0000, 1);
    checkLiteral("jge_neg_pc", pc, 12'h125);
    applyStimulus(0, 12'h000, 16'h0000, 1);
    applyStimulus(5, 12'h050, 16'h7777, 1);
    checkLiteral("jge_zero_pc", pc, 12'h050);
    applyStimulus(6, 12'h0AA, 16'h1111, 1);
    checkLiteral("jne_zero_pc", pc, 12'h051);
    checkLiteral("jne_zero_acc", writedata, 0);
    applyStimulus(0, 12'h000, 16'h0001, 1);
    applyStimulus(6, 12'h0AA, 16'h0000, 1);
    checkLiteral("jne_one_pc", pc, 12'h0AA);

    applyStimulus(0, 12'h000, 16'h1234, 1);
    instr = 16'h1010; readdata = 16'h5555; validRead = 1;
    #1;
    checkLiteral("sto_data", writedata, 16'h1234);
    @(posedge clk);
    modelStep(1, 12'h010, 16'h5555);
    #1;
    checkLiteral("sto_pc", pc, 12'h0AC);
    checkLiteral("sto_acc", writedata, 16'h1234);
    applyStimulus(8, 12'h000, 16'h9999, 1);
    checkLiteral("out_pc", pc, 12'h0AD);
    applyStimulus(15, 12'hFFF, 16'h9999, 1);
    checkLiteral("nop_pc", pc, 12'h0AE);
    checkLiteral("nop_acc", writedata, 16'h1234);

    applyStimulus(4, 12'h007, 16'h0000, 1);
    applyStimulus(7, 12'h000, 16'h0000, 1);
    checkLiteral("stp_run", running, 0);
    checkLiteral("stp_pc", pc, 12'h007);
    for (int i = 0; i < 4; i++) applyStimulus((i % 2) ? 4 : 0, 12'h321, 16'hABCD, 1);
    checkLiteral("halt_pc", pc, 12'h007);
    checkLiteral("halt_acc", writedata, 16'h1234);
    checkLiteral("halt_run", running, 0);
    doReset();

    applyStimulus(4, 12'hFFF, 16'h0000, 1);
    applyStimulus(0, 12'h000, 16'h4321, 1);
    checkLiteral("pc_wrap", pc, 12'h000);
    checkLiteral("wrap_acc", writedata, 16'h4321);

    for (int i = 0; i < 400; i++) begin
      if (!mRun && $urandom_range(0, 3) == 0) doReset();
      else begin
        op = $urandom_range(0, 15);
        if (op == 7 && $urandom_range(0, 3) != 0) op = 9;
        applyStimulus(op, $urandom_range(0, 4095), $urandom_range(0, 65535), $urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    cmpEn = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
